// File: rtl/staggered_row_feeder.sv
// Row-staggering block feeder: row k of each accepted block is presented k cycles after row 0.
// Build option: define STAGGERED_ROW_FEEDER_HOLD_EN to keep each out_row slice until it is rewritten.
module staggered_row_feeder #(
  parameter int unsigned N_ROWS = 4,
  parameter int unsigned N_COLS = 4,
  parameter int unsigned PIX_W  = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [N_ROWS*N_COLS*PIX_W-1:0]   in_rows,
  input  logic [$clog2(N_ROWS+1)-1:0]      active_rows,
  output logic [N_ROWS*N_COLS*PIX_W-1:0]   out_row,
  output logic [N_ROWS-1:0]                out_valid,
  output logic                             done,
  output logic                             busy
);

  localparam int unsigned RowW = N_COLS * PIX_W;
  localparam int unsigned BlkW = N_ROWS * RowW;
  localparam int unsigned CntW = $clog2(N_ROWS + 1);
  localparam int unsigned IdxW = $clog2(N_ROWS);

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  state_e            state_q, state_d;
  logic [BlkW-1:0]   cur_q, cur_d, pend_q, pend_d;
  logic [CntW-1:0]   cur_r_q, cur_r_d, pend_r_q, pend_r_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic              pend_full_q, pend_full_d;
  logic              in_ready_q, in_ready_d;
  logic [BlkW-1:0]   out_row_q, out_row_d;
  logic [N_ROWS-1:0] out_valid_q, out_valid_d;
  logic              done_q, done_d;

  logic              xfer, last, slot, launch;
  logic [CntW-1:0]   in_r, launch_r;
  logic [BlkW-1:0]   launch_blk;
  logic [IdxW-1:0]   nxt_idx;

  assign xfer     = in_valid && in_ready_q;
  assign last     = (state_q == StEmit) && (CntW'(idx_q) == cur_r_q - CntW'(1));
  assign slot     = (state_q == StIdle) || last;
  assign nxt_idx  = idx_q + 1'b1;
  assign in_r     = (active_rows == '0 || active_rows > CntW'(N_ROWS)) ? CntW'(N_ROWS) : active_rows;

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    cur_r_d     = cur_r_q;
    idx_d       = idx_q;
    pend_d      = pend_q;
    pend_r_d    = pend_r_q;
    pend_full_d = pend_full_q;
    out_valid_d = '0;
    done_d      = 1'b0;
    launch      = 1'b0;
    launch_blk  = in_rows;
    launch_r    = in_r;
`ifdef STAGGERED_ROW_FEEDER_HOLD_EN
    out_row_d   = out_row_q;
`else
    out_row_d   = '0;
`endif

    if (slot) begin
      // The pending block always wins; in_ready is low while it is held.
      if (pend_full_q) begin
        launch      = 1'b1;
        launch_blk  = pend_q;
        launch_r    = pend_r_q;
        pend_full_d = 1'b0;
      end else if (xfer) begin
        launch = 1'b1;
      end else begin
        state_d = StIdle;
      end
    end else if (state_q == StEmit) begin
      idx_d                               = nxt_idx;
      out_valid_d[nxt_idx]                = 1'b1;
      out_row_d[nxt_idx*RowW +: RowW]     = cur_q[nxt_idx*RowW +: RowW];
      done_d                              = (CntW'(nxt_idx) == cur_r_q - CntW'(1));
    end

    if (launch) begin
      state_d              = StEmit;
      cur_d                = launch_blk;
      cur_r_d              = launch_r;
      idx_d                = '0;
      out_valid_d[0]       = 1'b1;
      out_row_d[RowW-1:0]  = launch_blk[RowW-1:0];
      done_d               = (launch_r == CntW'(1));
    end

    if (xfer && !slot) begin
      pend_d      = in_rows;
      pend_r_d    = in_r;
      pend_full_d = 1'b1;
    end

    in_ready_d = !pend_full_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cur_q       <= '0;
      cur_r_q     <= '0;
      idx_q       <= '0;
      pend_q      <= '0;
      pend_r_q    <= '0;
      pend_full_q <= 1'b0;
      in_ready_q  <= 1'b1;
      out_row_q   <= '0;
      out_valid_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      cur_r_q     <= cur_r_d;
      idx_q       <= idx_d;
      pend_q      <= pend_d;
      pend_r_q    <= pend_r_d;
      pend_full_q <= pend_full_d;
      in_ready_q  <= in_ready_d;
      out_row_q   <= out_row_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_row   = out_row_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign busy      = (state_q == StEmit) || pend_full_q;

endmodule
